// File: rtl/tm1638_responder.sv
// rtl/tm1638_responder.sv - TM1638 slave-side responder: frame decode, display RAM, key-scan readback
module tm1638_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK_IN,
  input  logic        RST_IN,
  input  logic        TM1638_STB,
  input  logic        TM1638_CLK,
  inout  wire         TM1638_DIO,
  input  logic [31:0] KEYS_IN,
  output logic        DISP_ON,
  output logic [2:0]  DISP_BRIGHT,
  output logic        WR_STROBE,
  output logic [3:0]  WR_ADDR,
  output logic [7:0]  WR_DATA,
  input  logic [3:0]  RAM_RD_ADDR,
  output logic [7:0]  RAM_RD_DATA
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    WDATA  = 3'd2,
    RKEY   = 3'd3,
    IGNORE = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] stb_sync, clk_sync, dio_sync;
  logic        clk_prev;
  logic        stb_s, clk_s, dio_s;
  logic        rise, fall;

  logic [5:0]  bit_cnt;
  logic [6:0]  sh_in;
  logic [7:0]  cmd_byte;
  logic        byte_done;
  logic [31:0] keys_sh;
  logic [3:0]  addr;
  logic        fixed_addr;
  logic        dio_oe;
  logic [7:0]  ram [16];

  assign stb_s = stb_sync[SYNC_STAGES-1];
  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dio_s = dio_sync[SYNC_STAGES-1];
  assign rise  = clk_s & ~clk_prev;
  assign fall  = ~clk_s & clk_prev;

  // Byte under assembly, including the bit arriving on this rising edge.
  assign cmd_byte  = {dio_s, sh_in};
  assign byte_done = rise && (bit_cnt[2:0] == 3'd7);

  assign TM1638_DIO = dio_oe ? 1'b0 : 1'bz;

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      // Coming out of reset we cannot know where in a frame we are.
      state_q <= IGNORE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stb_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = CMD;
        CMD: begin
          if (byte_done) begin
            case (cmd_byte[7:6])
              2'b01:   state_d = (cmd_byte[1:0] == 2'b10) ? RKEY : IGNORE;
              2'b11:   state_d = WDATA;
              default: state_d = IGNORE;
            endcase
          end
        end
        WDATA:   state_d = WDATA;
        RKEY:    state_d = RKEY;
        IGNORE:  state_d = IGNORE;
        default: state_d = IGNORE;
      endcase
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      stb_sync    <= '0;
      clk_sync    <= '0;
      dio_sync    <= '1;
      clk_prev    <= 1'b0;
      bit_cnt     <= 6'd0;
      sh_in       <= 7'd0;
      keys_sh     <= 32'd0;
      addr        <= 4'd0;
      fixed_addr  <= 1'b0;
      dio_oe      <= 1'b0;
      DISP_ON     <= 1'b0;
      DISP_BRIGHT <= 3'd0;
      WR_STROBE   <= 1'b0;
      WR_ADDR     <= 4'd0;
      WR_DATA     <= 8'd0;
      RAM_RD_DATA <= 8'd0;
      for (int i = 0; i < 16; i++) begin
        ram[i] <= 8'd0;
      end
    end else begin
      stb_sync    <= {stb_sync[SYNC_STAGES-2:0], TM1638_STB};
      clk_sync    <= {clk_sync[SYNC_STAGES-2:0], TM1638_CLK};
      dio_sync    <= {dio_sync[SYNC_STAGES-2:0], TM1638_DIO};
      clk_prev    <= clk_s;
      WR_STROBE   <= 1'b0;
      RAM_RD_DATA <= ram[RAM_RD_ADDR];

      if (stb_s) begin
        dio_oe  <= 1'b0;
        bit_cnt <= 6'd0;
      end else begin
        case (state_q)
          IDLE: bit_cnt <= 6'd0;
          CMD: begin
            if (rise) begin
              sh_in <= {dio_s, sh_in[6:1]};
              if (byte_done) begin
                bit_cnt <= 6'd0;
                case (cmd_byte[7:6])
                  2'b01: begin
                    if (!cmd_byte[0]) begin
                      fixed_addr <= cmd_byte[2];
                      if (cmd_byte[1]) keys_sh <= KEYS_IN;
                    end
                  end
                  2'b10: begin
                    DISP_ON     <= cmd_byte[3];
                    DISP_BRIGHT <= cmd_byte[2:0];
                  end
                  2'b11:   addr <= cmd_byte[3:0];
                  default: ;
                endcase
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
              end
            end
          end
          WDATA: begin
            if (rise) begin
              sh_in   <= {dio_s, sh_in[6:1]};
              bit_cnt <= bit_cnt + 6'd1;
              if (byte_done) begin
                ram[addr] <= cmd_byte;
                WR_STROBE <= 1'b1;
                WR_ADDR   <= addr;
                WR_DATA   <= cmd_byte;
                if (!fixed_addr) addr <= addr + 4'd1;
              end
            end
          end
          RKEY: begin
            // Once 32 bits have gone out the line stays released.
            if (bit_cnt < 6'd32) begin
              if (fall) dio_oe <= ~keys_sh[0];
              if (rise) begin
                keys_sh <= keys_sh >> 1;
                bit_cnt <= bit_cnt + 6'd1;
                if (bit_cnt == 6'd31) dio_oe <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tm1638_responder.sv
// tb/tb_tm1638_responder.sv - directed self-checking bench for tm1638_responder
module tb_tm1638_responder;

  localparam int HALF = 8;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        stb = 1'b1;
  logic        tclk = 1'b1;
  logic        tb_oe = 1'b0;
  logic        tb_dio = 1'b1;
  logic [31:0] keys = 32'd0;
  logic [3:0]  rd_addr = 4'd0;
  logic        disp_on;
  logic [2:0]  disp_bright;
  logic        wr_strobe;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  ram_rd_data;
  wire         dio;

  pullup (dio);
  assign dio = tb_oe ? tb_dio : 1'bz;

  always #5 clk_in = ~clk_in;

  tm1638_responder #(.SYNC_STAGES(2)) dut (
    .CLK_IN(clk_in), .RST_IN(rst_in), .TM1638_STB(stb), .TM1638_CLK(tclk),
    .TM1638_DIO(dio), .KEYS_IN(keys), .DISP_ON(disp_on), .DISP_BRIGHT(disp_bright),
    .WR_STROBE(wr_strobe), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .RAM_RD_ADDR(rd_addr), .RAM_RD_DATA(ram_rd_data)
  );

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int low_cnt = 0;
  logic [3:0] last_addr = 4'd0;
  logic [7:0] last_data = 8'd0;

  // Records write pulses and any DUT pull-down of DIO while the bench is not driving.
  always @(negedge clk_in) begin
    if (wr_strobe === 1'b1) begin
      wr_cnt++;
      last_addr = wr_addr;
      last_data = wr_data;
    end
    if (!tb_oe && dio === 1'b0) low_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      tclk = 1'b0; tb_oe = 1'b1; tb_dio = b[i];
      wait_clk(HALF);
      tclk = 1'b1;
      wait_clk(HALF);
    end
  endtask

  task automatic read_bits(input int n, output logic [31:0] v);
    v = 32'd0;
    for (int i = 0; i < n; i++) begin
      tclk = 1'b0;
      wait_clk(HALF);
      tclk = 1'b1;
      v[i] = (dio !== 1'b0);
      wait_clk(HALF);
    end
  endtask

  task automatic end_frame;
    tb_oe = 1'b0;
    wait_clk(HALF);
    stb = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic frame(input logic [7:0] b0, b1, b2, b3, input int n);
    stb = 1'b0;
    wait_clk(HALF);
    send_bits(b0, 8);
    if (n > 1) send_bits(b1, 8);
    if (n > 2) send_bits(b2, 8);
    if (n > 3) send_bits(b3, 8);
    end_frame();
  endtask

  task automatic read_ram(input logic [3:0] a, output logic [7:0] d);
    rd_addr = a;
    @(posedge clk_in);
    @(negedge clk_in);
    d = ram_rd_data;
  endtask

  task automatic test_reset;
    rst_in = 1'b1;
    wait_clk(4);
    rst_in = 1'b0;
    wait_clk(6);
    checks++; if (disp_on !== 1'b0) begin failures++; $display("FAIL reset_disp_on got=%0h exp=0", disp_on); end
    checks++; if (disp_bright !== 3'd0) begin failures++; $display("FAIL reset_bright got=%0h exp=0", disp_bright); end
    checks++; if (wr_strobe !== 1'b0) begin failures++; $display("FAIL reset_wr_strobe got=%0h exp=0", wr_strobe); end
    checks++; if (wr_addr !== 4'd0 || wr_data !== 8'd0) begin failures++; $display("FAIL reset_wr_bus got=%0h/%0h exp=0/0", wr_addr, wr_data); end
    checks++; if (ram_rd_data !== 8'd0) begin failures++; $display("FAIL reset_rd_data got=%0h exp=0", ram_rd_data); end
    checks++; if (dio === 1'b0) begin failures++; $display("FAIL reset_dio got=%0b exp=released", dio); end
  endtask

  task automatic test_disp_ctrl;
    int wr0, low0;
    wr0 = wr_cnt; low0 = low_cnt;
    frame(8'h8F, 8'h00, 8'h00, 8'h00, 1);
    checks++; if (disp_on !== 1'b1) begin failures++; $display("FAIL ctrl_disp_on got=%0h exp=1", disp_on); end
    checks++; if (disp_bright !== 3'd7) begin failures++; $display("FAIL ctrl_bright got=%0h exp=7", disp_bright); end
    checks++; if (wr_cnt - wr0 !== 0) begin failures++; $display("FAIL ctrl_no_write got=%0d exp=0", wr_cnt - wr0); end
    checks++; if (low_cnt - low0 !== 0) begin failures++; $display("FAIL ctrl_dio_driven got=%0d exp=0", low_cnt - low0); end
  endtask

  task automatic test_fixed_write;
    int wr0;
    logic [7:0] d;
    wr0 = wr_cnt;
    frame(8'h44, 8'h00, 8'h00, 8'h00, 1);
    frame(8'hC6, 8'h06, 8'h00, 8'h00, 2);
    checks++; if (wr_cnt - wr0 !== 1) begin failures++; $display("FAIL fixed_wr_count got=%0d exp=1", wr_cnt - wr0); end
    checks++; if (last_addr !== 4'd6 || last_data !== 8'h06) begin failures++; $display("FAIL fixed_wr_bus got=%0h/%0h exp=6/06", last_addr, last_data); end
    for (int a = 0; a < 16; a++) begin
      read_ram(a[3:0], d);
      checks++;
      if (d !== ((a == 6) ? 8'h06 : 8'h00)) begin failures++; $display("FAIL fixed_ram[%0d] got=%0h exp=%0h", a, d, (a == 6) ? 8'h06 : 8'h00); end
    end
  endtask

  task automatic test_auto_wrap;
    int wr0;
    logic [7:0] d;
    wr0 = wr_cnt;
    frame(8'h40, 8'h00, 8'h00, 8'h00, 1);
    frame(8'hCF, 8'h11, 8'h22, 8'h33, 4);
    checks++; if (wr_cnt - wr0 !== 3) begin failures++; $display("FAIL wrap_wr_count got=%0d exp=3", wr_cnt - wr0); end
    checks++; if (last_addr !== 4'd1 || last_data !== 8'h33) begin failures++; $display("FAIL wrap_last_bus got=%0h/%0h exp=1/33", last_addr, last_data); end
    read_ram(4'd15, d);
    checks++; if (d !== 8'h11) begin failures++; $display("FAIL wrap_ram15 got=%0h exp=11", d); end
    read_ram(4'd0, d);
    checks++; if (d !== 8'h22) begin failures++; $display("FAIL wrap_ram0 got=%0h exp=22", d); end
    read_ram(4'd1, d);
    checks++; if (d !== 8'h33) begin failures++; $display("FAIL wrap_ram1 got=%0h exp=33", d); end
    read_ram(4'd6, d);
    checks++; if (d !== 8'h06) begin failures++; $display("FAIL wrap_ram6 got=%0h exp=06", d); end
  endtask

  task automatic test_key_read;
    logic [31:0] v, v2;
    int low0;
    keys = 32'h1000_0001;
    stb = 1'b0;
    wait_clk(HALF);
    send_bits(8'h42, 8);
    tb_oe = 1'b0;
    read_bits(32, v);
    checks++; if (v[7:0] !== 8'h01) begin failures++; $display("FAIL key_byte0 got=%0h exp=01", v[7:0]); end
    checks++; if (v[15:8] !== 8'h00) begin failures++; $display("FAIL key_byte1 got=%0h exp=00", v[15:8]); end
    checks++; if (v[23:16] !== 8'h00) begin failures++; $display("FAIL key_byte2 got=%0h exp=00", v[23:16]); end
    checks++; if (v[31:24] !== 8'h10) begin failures++; $display("FAIL key_byte3 got=%0h exp=10", v[31:24]); end
    checks++; if (dio === 1'b0) begin failures++; $display("FAIL key_dio_after32 got=%0b exp=released", dio); end
    low0 = low_cnt;
    read_bits(4, v2);
    checks++; if (low_cnt - low0 !== 0 || v2[3:0] !== 4'hF) begin failures++; $display("FAIL key_extra_clocks got=%0d/%0h exp=0/f", low_cnt - low0, v2[3:0]); end
    stb = 1'b1;
    wait_clk(2 * HALF);
    checks++; if (dio === 1'b0) begin failures++; $display("FAIL key_dio_after_stb got=%0b exp=released", dio); end
  endtask

  task automatic test_abort;
    int wr0;
    logic [7:0] d;
    wr0 = wr_cnt;
    stb = 1'b0;
    wait_clk(HALF);
    send_bits(8'hC6, 4);
    end_frame();
    frame(8'h8A, 8'h00, 8'h00, 8'h00, 1);
    checks++; if (wr_cnt - wr0 !== 0) begin failures++; $display("FAIL abort_no_write got=%0d exp=0", wr_cnt - wr0); end
    checks++; if (disp_on !== 1'b1 || disp_bright !== 3'd2) begin failures++; $display("FAIL abort_ctrl got=%0h/%0h exp=1/2", disp_on, disp_bright); end
    read_ram(4'd6, d);
    checks++; if (d !== 8'h06) begin failures++; $display("FAIL abort_ram6 got=%0h exp=06", d); end
  endtask

  task automatic test_reset_mid_read;
    logic [31:0] v;
    logic [7:0] d;
    int wr0, low0;
    keys = 32'h0000_0000;
    stb = 1'b0;
    wait_clk(HALF);
    send_bits(8'h42, 8);
    tb_oe = 1'b0;
    read_bits(10, v);
    tclk = 1'b0;
    wait_clk(HALF);
    checks++; if (dio !== 1'b0) begin failures++; $display("FAIL midrd_dio_driven got=%0b exp=0", dio); end
    rst_in = 1'b1;
    wait_clk(1);
    rst_in = 1'b0;
    checks++; if (dio === 1'b0) begin failures++; $display("FAIL midrd_dio_released got=%0b exp=released", dio); end
    checks++; if (disp_on !== 1'b0 || disp_bright !== 3'd0) begin failures++; $display("FAIL midrd_ctrl_reset got=%0h/%0h exp=0/0", disp_on, disp_bright); end
    checks++; if (wr_strobe !== 1'b0 || wr_addr !== 4'd0 || wr_data !== 8'd0 || ram_rd_data !== 8'd0) begin failures++; $display("FAIL midrd_outputs_reset got=%0h/%0h/%0h/%0h exp=0/0/0/0", wr_strobe, wr_addr, wr_data, ram_rd_data); end
    wr0 = wr_cnt; low0 = low_cnt;
    send_bits(8'h8F, 8);
    send_bits(8'h8F, 8);
    send_bits(8'h8F, 6);
    end_frame();
    checks++; if (disp_on !== 1'b0 || wr_cnt - wr0 !== 0 || low_cnt - low0 !== 0) begin failures++; $display("FAIL midrd_ignored got=%0h/%0d/%0d exp=0/0/0", disp_on, wr_cnt - wr0, low_cnt - low0); end
    read_ram(4'd6, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL midrd_ram_cleared got=%0h exp=00", d); end
    frame(8'h8F, 8'h00, 8'h00, 8'h00, 1);
    checks++; if (disp_on !== 1'b1 || disp_bright !== 3'd7) begin failures++; $display("FAIL midrd_next_frame got=%0h/%0h exp=1/7", disp_on, disp_bright); end
  endtask

  initial begin
    test_reset();
    test_disp_ctrl();
    test_fixed_write();
    test_auto_wrap();
    test_key_read();
    test_abort();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tm1638_responder.md
Name: tm1638_responder

Overview:
- Synthesizable slave-side model of the TM1638 serial interface. It is the responder to the tm1638BtmDisp controller.
- Accepts STB/CLK/DIO frames and decodes data, display-control and address commands.
- Stores the 16-byte display RAM and returns 4 key-scan bytes on read commands.
- Used for FPGA loopback testing and as a chip model in the controller's system benches.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on TM1638_STB/CLK/DIO inputs (legal values ≥2).

Ports:
- CLK_IN  input  1  system clock; all logic on rising edge.
- RST_IN  input  1  synchronous reset, active-high.
- TM1638_STB  input  1  frame strobe, active-low.
- TM1638_CLK  input  1  serial clock from controller.
- TM1638_DIO  inout  1  open-drain data line, pulled up externally. The block only drives 0 or z.
- KEYS_IN  input  32  key-scan bytes: byte0 = [7:0] … byte3 = [31:24].
- DISP_ON  output  1  display enable from the last display-control command.
- DISP_BRIGHT  output  3  brightness from the last display-control command.
- WR_STROBE  output  1  one-cycle pulse per display-RAM write.
- WR_ADDR  output  4  address of the current write; valid with WR_STROBE.
- WR_DATA  output  8  data of the current write; valid with WR_STROBE.
- RAM_RD_ADDR  input  4  display-RAM read address.
- RAM_RD_DATA  output  8  display-RAM read data, registered.

Behaviour:
- Input synchronisation:
  - STB, CLK and DIO pass through SYNC_STAGES flops.
  - CLK edges are detected on the synchronised copy.
  - Requirement on the controller: TM1638_CLK high and low phases are each ≥ SYNC_STAGES+3 CLK_IN cycles.
- Bit order and timing:
  - Bits are LSB first.
  - Input bits are sampled on the detected rising edge of TM1638_CLK.
  - Output bits are driven after the detected falling edge, within SYNC_STAGES+1 CLK_IN cycles.
- States: IDLE, CMD, WDATA, RKEY, IGNORE.
- IDLE: synchronised STB low → CMD, with bit counter cleared.
- CMD: on the 8th rising edge, decode bits [7:6]:
  - 01, data command:
    - bit1 = read, bit2 = fixed address (0 = auto-increment); latch both.
    - [1:0] = 00 (write): stay framed in IGNORE. The mode is stored for later address frames.
    - [1:0] = 10 (read): snapshot KEYS_IN into a 32-bit shift register, clear the bit counter, go to RKEY.
    - [1:0] = 01 or 11: go to IGNORE with no register change.
  - 10, display control:
    - DISP_ON ← bit3, DISP_BRIGHT ← [2:0], both updated in the cycle after byte completion.
    - Then go to IGNORE.
  - 11, address: addr ← [3:0], go to WDATA.
  - 00: go to IGNORE.
- WDATA, on each completed byte:
  - RAM[addr] ← byte.
  - WR_STROBE = 1 for one cycle, with WR_ADDR = addr and WR_DATA = byte.
  - If auto-increment: addr ← addr+1 mod 16 (15 wraps to 0). If fixed: addr is unchanged.
  - There is no limit on the number of data bytes.
- RKEY:
  - On each falling edge, for bits 0..31: drive DIO low if the bit is 0, else release (z).
  - After the 32nd bit's rising edge, release DIO permanently for the rest of the frame.
  - Extra clocks produce no further data.
  - DIO is never driven in any state other than RKEY.
- IGNORE: all clocks are ignored until STB goes high.
- Frame end: synchronised STB high in any state takes these actions in that cycle:
  - DIO released, state → IDLE.
  - A partial byte is discarded; completed writes persist.
  - STB rise coinciding with a CLK edge: STB wins and the edge is ignored.
- Reset values:
  - DISP_ON 0, DISP_BRIGHT 0, all 16 RAM bytes 0x00.
  - addr 0, mode write with auto-increment.
  - WR_STROBE 0, WR_ADDR 0, WR_DATA 0, RAM_RD_DATA 0.
  - DIO released.
- Reset released while STB is low: the block enters IGNORE and waits for STB high, so it never decodes a misaligned frame.
- RAM read port:
  - RAM_RD_DATA = RAM[RAM_RD_ADDR], 1-cycle latency.
  - A same-cycle write to the same address returns the old data; the new data appears one cycle later.

Test Plan:
- Reset, then frame byte 0x8F → DISP_ON=1, DISP_BRIGHT=7. No WR_STROBE, DIO never driven.
- Frame 0x44, then frame 0xC6,0x06 → exactly one WR_STROBE with WR_ADDR=6, WR_DATA=0x06. RAM_RD_ADDR=6 gives 0x06 one cycle later; all other addresses stay 0x00.
- Frame 0x40, then frame 0xCF,0x11,0x22,0x33 → RAM[15]=0x11, RAM[0]=0x22, RAM[1]=0x33 (wrap). Three WR_STROBE pulses.
- KEYS_IN=32'h1000_0001, frame 0x42 then 32 clocks, sampling DIO on rising edges → controller reads 0x01, 0x00, 0x00, 0x10. DIO is z after the 32nd bit and after STB high.
- Frame 0xC6 aborted by STB high after 4 bits, then full frame 0x8A → no write. DISP_ON=1, DISP_BRIGHT=2.
- Frame 0x42, then RST_IN pulsed after 10 read bits with STB kept low → DIO released the cycle after reset and all outputs at reset values. The remaining clocks are ignored; the next full frame 0x8F decodes correctly.
